// File: rtl/serial_shares_words_tx_pkg.sv
// Shared constants and FSM encoding for the serial share/word transmitter.
package serial_shares_words_tx_pkg;

  localparam int d                   = 2;
  localparam int MAX_WORDS_PER_SHARE = 8;
  localparam int WORD_BITS           = 32;
  localparam int NBITS               = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/tx_share_word_cnt.sv
// Bounded share/word index counter: walks words 0..bound of each share, share-major.
module tx_share_word_cnt
  import serial_shares_words_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [NBITS-1:0] bound,
  output logic [NBITS-1:0] share_idx,
  output logic [NBITS-1:0] word_idx,
  output logic             last
);

  logic last_word;
  logic last_share;

  assign last_word  = (word_idx == bound);
  assign last_share = (share_idx == NBITS'(d - 1));
  assign last       = last_word && last_share;

  // Share index saturates at d-1 so an unexpected extra inc can never wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      share_idx <= '0;
      word_idx  <= '0;
    end else if (inc) begin
      if (!last_word) begin
        word_idx <= word_idx + NBITS'(1);
      end else begin
        word_idx <= '0;
        if (!last_share) share_idx <= share_idx + NBITS'(1);
      end
    end
  end

endmodule

// File: rtl/serial_shares_words_tx.sv
// Buffers one parallel masked block and streams it out as share-major serial words.
module serial_shares_words_tx
  import serial_shares_words_tx_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [d*MAX_WORDS_PER_SHARE*WORD_BITS-1:0] in_data,
  input  logic [NBITS-1:0]                         words_per_share_bound,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [WORD_BITS-1:0]                     out_data,
  output logic [NBITS-1:0]                         out_share_idx,
  output logic [NBITS-1:0]                         out_word_idx,
  output logic                                     out_last,
  output logic                                     busy
);

  function automatic logic [NBITS-1:0] sat_bound(input logic [NBITS-1:0] b);
    return (b > NBITS'(MAX_WORDS_PER_SHARE - 1)) ? NBITS'(MAX_WORDS_PER_SHARE - 1) : b;
  endfunction

  tx_state_t            state;
  logic [WORD_BITS-1:0] buf_mem [d][MAX_WORDS_PER_SHARE];
  logic [NBITS-1:0]     bound_lat;
  logic                 cnt_last;
  logic                 load;
  logic                 xfer;
  logic                 blk_end;
  logic [WORD_BITS-1:0] word_sel;

  assign out_valid = (state == SEND);
  assign busy      = out_valid;
  assign out_last  = out_valid && cnt_last;
  // Accepting on the final transfer gives back-to-back blocks with no bubble.
  assign in_ready  = (state == IDLE) || (out_last && out_ready);
  assign load      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign blk_end   = xfer && out_last;

  tx_share_word_cnt u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (load || blk_end),
    .inc       (xfer),
    .bound     (bound_lat),
    .share_idx (out_share_idx),
    .word_idx  (out_word_idx),
    .last      (cnt_last)
  );

  always_comb begin
    word_sel = '0;
    for (int s = 0; s < d; s++) begin
      for (int w = 0; w < MAX_WORDS_PER_SHARE; w++) begin
        if (out_share_idx == NBITS'(s) && out_word_idx == NBITS'(w)) word_sel = buf_mem[s][w];
      end
    end
  end

  assign out_data = word_sel & {WORD_BITS{out_valid}};

  // Buffer is wiped when a block finishes so no share material lingers while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bound_lat <= '0;
      for (int s = 0; s < d; s++)
        for (int w = 0; w < MAX_WORDS_PER_SHARE; w++)
          buf_mem[s][w] <= '0;
    end else if (load) begin
      state     <= SEND;
      bound_lat <= sat_bound(words_per_share_bound);
      for (int s = 0; s < d; s++)
        for (int w = 0; w < MAX_WORDS_PER_SHARE; w++)
          buf_mem[s][w] <= in_data[(s*MAX_WORDS_PER_SHARE + w)*WORD_BITS +: WORD_BITS];
    end else if (blk_end) begin
      state <= IDLE;
      for (int s = 0; s < d; s++)
        for (int w = 0; w < MAX_WORDS_PER_SHARE; w++)
          buf_mem[s][w] <= '0;
    end
  end

endmodule
